// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores over a req/ack handshake with a
// bounded wait, passes ALU results through and registers writeback results.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_alu_result,
  input  logic [15:0] in_write_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_halt,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [15:0] wb_alu_result,
  output logic [15:0] wb_read_data,
  output logic        wb_is_load,
  output logic        wb_halt,
  output logic        wb_err
);

  // The counter only has to reach TIMEOUT-1: the timeout fires on that cycle.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [15:0]   addr_q, wdata_q;
  logic          op_load_q, op_wr_q;
  logic          load_entry;

  logic          wbn_valid;
  logic [15:0]   wbn_alu_result;
  logic [15:0]   wbn_read_data;
  logic          wbn_is_load;
  logic          wbn_halt;
  logic          wbn_err;

  assign in_ready  = (state == IDLE);
  assign mem_req   = (state == BUSY);
  assign mem_wr    = (state == BUSY) && op_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Writeback fields stay zero unless a branch below produces a result.
  always_comb begin
    state_next     = state;
    count_next     = count;
    load_entry     = 1'b0;
    wbn_valid      = 1'b0;
    wbn_alu_result = 16'h0000;
    wbn_read_data  = 16'h0000;
    wbn_is_load    = 1'b0;
    wbn_halt       = 1'b0;
    wbn_err        = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_halt) begin
            wbn_valid      = 1'b1;
            wbn_halt       = 1'b1;
            wbn_alu_result = in_alu_result;
            state_next     = HALTED;
          end else if (in_mem_read && in_mem_write) begin
            // Conflicting op: reported as a failed load, memory untouched
            wbn_valid      = 1'b1;
            wbn_is_load    = 1'b1;
            wbn_err        = 1'b1;
            wbn_alu_result = in_alu_result;
          end else if (in_mem_read || in_mem_write) begin
            if (in_alu_result[0]) begin
              wbn_valid      = 1'b1;
              wbn_is_load    = in_mem_read;
              wbn_err        = 1'b1;
              wbn_alu_result = in_alu_result;
            end else begin
              load_entry = 1'b1;
              state_next = BUSY;
              count_next = '0;
            end
          end else begin
            wbn_valid      = 1'b1;
            wbn_alu_result = in_alu_result;
          end
        end
      end

      BUSY: begin
        // An ack on the timeout cycle still completes the access
        if (mem_ack) begin
          wbn_valid      = 1'b1;
          wbn_alu_result = addr_q;
          wbn_is_load    = op_load_q;
          wbn_read_data  = op_load_q ? mem_rdata : 16'h0000;
          state_next     = IDLE;
          count_next     = '0;
        end else if (count == LAST) begin
          wbn_valid      = 1'b1;
          wbn_alu_result = addr_q;
          wbn_is_load    = op_load_q;
          wbn_err        = 1'b1;
          state_next     = IDLE;
          count_next     = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end

      HALTED: begin
        state_next = HALTED;
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      op_load_q     <= 1'b0;
      op_wr_q       <= 1'b0;
      wb_valid      <= 1'b0;
      wb_alu_result <= 16'h0000;
      wb_read_data  <= 16'h0000;
      wb_is_load    <= 1'b0;
      wb_halt       <= 1'b0;
      wb_err        <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      wb_valid      <= wbn_valid;
      wb_alu_result <= wbn_alu_result;
      wb_read_data  <= wbn_read_data;
      wb_is_load    <= wbn_is_load;
      wb_halt       <= wbn_halt;
      wb_err        <= wbn_err;
      if (load_entry) begin
        addr_q    <= in_alu_result;
        wdata_q   <= in_write_data;
        op_load_q <= in_mem_read;
        op_wr_q   <= in_mem_write;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout; memory ack/data are
// driven by hand at each step and every result is a hand-computed constant.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_alu_result;
  logic [15:0] in_write_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_halt;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [15:0] wb_alu_result;
  logic [15:0] wb_read_data;
  logic        wb_is_load;
  logic        wb_halt;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_alu_result),
    .in_write_data (in_write_data),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_halt       (in_halt),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .wb_valid      (wb_valid),
    .wb_alu_result (wb_alu_result),
    .wb_read_data  (wb_read_data),
    .wb_is_load    (wb_is_load),
    .wb_halt       (wb_halt),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] alu,
                               input logic [15:0] wdata, input logic rd,
                               input logic wr, input logic hlt);
    in_valid      = v;
    in_alu_result = alu;
    in_write_data = wdata;
    in_mem_read   = rd;
    in_mem_write  = wr;
    in_halt       = hlt;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {15'd0, observed}, {15'd0, expected});
  endtask

  // Full writeback snapshot plus the request line
  task automatic checkWb(input string tag, input logic v, input logic [15:0] alu,
                         input logic [15:0] rdata, input logic ld, input logic hlt,
                         input logic err, input logic req);
    checkFlag({tag, ".wb_valid"}, wb_valid, v);
    checkOutput({tag, ".wb_alu_result"}, wb_alu_result, alu);
    checkOutput({tag, ".wb_read_data"}, wb_read_data, rdata);
    checkFlag({tag, ".wb_is_load"}, wb_is_load, ld);
    checkFlag({tag, ".wb_halt"}, wb_halt, hlt);
    checkFlag({tag, ".wb_err"}, wb_err, err);
    checkFlag({tag, ".mem_req"}, mem_req, req);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    $display("[TB] reset state");
    checkWb("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("reset.in_ready", in_ready, 1'b1);
    checkFlag("reset.mem_wr", mem_wr, 1'b0);
    checkOutput("reset.mem_addr", mem_addr, 16'h0000);
    checkOutput("reset.mem_wdata", mem_wdata, 16'h0000);
    rst = 1'b0;

    $display("[TB] non-memory back-to-back");
    applyStimulus(1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
    checkWb("nm1", 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("nm1.in_ready", in_ready, 1'b1);
    applyStimulus(1'b1, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    checkWb("nm2", 1'b1, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("nm2.in_ready", in_ready, 1'b1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    checkWb("nm_idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] load acked in third busy cycle");
    applyStimulus(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkWb("ld.b1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ld.b1.mem_addr", mem_addr, 16'h0040);
    checkFlag("ld.b1.mem_wr", mem_wr, 1'b0);
    checkFlag("ld.b1.in_ready", in_ready, 1'b0);
    tick();
    checkFlag("ld.b2.mem_req", mem_req, 1'b1);
    checkFlag("ld.b2.wb_valid", wb_valid, 1'b0);
    tick();
    checkFlag("ld.b3.mem_req", mem_req, 1'b1);
    checkOutput("ld.b3.mem_addr", mem_addr, 16'h0040);
    checkFlag("ld.b3.in_ready", in_ready, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    checkWb("ld.done", 1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkFlag("ld.done.in_ready", in_ready, 1'b1);
    tick();
    checkWb("ld.after", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] store with immediate ack");
    applyStimulus(1'b1, 16'h0102, 16'hA5A5, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkFlag("st.b1.mem_req", mem_req, 1'b1);
    checkFlag("st.b1.mem_wr", mem_wr, 1'b1);
    checkOutput("st.b1.mem_addr", mem_addr, 16'h0102);
    checkOutput("st.b1.mem_wdata", mem_wdata, 16'hA5A5);
    checkFlag("st.b1.wb_valid", wb_valid, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    checkWb("st.done", 1'b1, 16'h0102, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("st.done.mem_wr", mem_wr, 1'b0);

    $display("[TB] unaligned load");
    applyStimulus(1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkWb("unal", 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFlag("unal.in_ready", in_ready, 1'b1);
    tick();
    checkWb("unal.after", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] read and write together");
    applyStimulus(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkWb("both", 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] timeout without ack");
    applyStimulus(1'b1, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      checkFlag($sformatf("to.b%0d.mem_req", i), mem_req, 1'b1);
      checkFlag($sformatf("to.b%0d.wb_valid", i), wb_valid, 1'b0);
      if (i < TIMEOUT) tick();
    end
    tick();
    checkWb("to.done", 1'b1, 16'h0200, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    checkFlag("to.done.in_ready", in_ready, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    checkWb("to.late_ack", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("to.late_ack.in_ready", in_ready, 1'b1);

    $display("[TB] ack on the timeout cycle");
    applyStimulus(1'b1, 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkFlag("to4.b4.mem_req", mem_req, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hCAFE;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    checkWb("to4.done", 1'b1, 16'h0300, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during busy load");
    applyStimulus(1'b1, 16'h0050, 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    checkFlag("rb.b2.mem_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkWb("rb.reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFlag("rb.reset.in_ready", in_ready, 1'b1);
    tick();
    checkWb("rb.after", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] halt");
    applyStimulus(1'b1, 16'h0AAA, 16'h5555, 1'b1, 1'b0, 1'b1);
    tick();
    checkWb("halt", 1'b1, 16'h0AAA, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkFlag("halt.in_ready", in_ready, 1'b0);
    applyStimulus(1'b1, 16'h1110, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkFlag($sformatf("halted%0d.in_ready", i), in_ready, 1'b0);
      checkFlag($sformatf("halted%0d.wb_valid", i), wb_valid, 1'b0);
      checkFlag($sformatf("halted%0d.mem_req", i), mem_req, 1'b0);
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkFlag("halt.reset.in_ready", in_ready, 1'b1);
    checkWb("halt.reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
